// File: rtl/mesh_link_pkg.sv
// mesh_link_pkg: shared state type, header layout and packet-length decode for the mesh link arbiter
package mesh_link_pkg;

    localparam int WORD_CNT_W = 7;

    // Header word layout: [31:24] mes_type, [23:16] des_addr, [15:8] byte_len, [7:0] source
    localparam int HDR_FIELD_W  = 8;
    localparam int HDR_LEN_LSB  = 8;

    typedef struct packed {
        logic [7:0] mes_type;
        logic [7:0] des_addr;
        logic [7:0] byte_len;
        logic [7:0] source;
    } hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RLS,
        WAIT_ACKLO,
        NEXT
    } state_t;

    // Header word plus one word per started group of four payload bytes (1..65)
    function automatic logic [WORD_CNT_W-1:0] HDR_WORDS(input logic [HDR_FIELD_W-1:0] byte_len);
        return WORD_CNT_W'((10'(byte_len) + 10'd3) / 10'd4 + 10'd1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin picker, first request at or after ptr with wrap
module rr_picker #(
    parameter int N_PORTS = 4,
    localparam int IW = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               gnt_valid,
    output logic [IW-1:0]      gnt_idx
);

    logic [IW:0]   s;
    logic [IW-1:0] idx;

    // Scan from farthest to nearest offset so the nearest requester is the last writer
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx = '0;
        s = '0;
        idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (IW+1)'(i);
            idx = s >= (IW+1)'(N_PORTS) ? IW'(s - (IW+1)'(N_PORTS)) : IW'(s);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mesh_link_arbiter.sv
// mesh_link_arbiter: packet-granular round-robin arbiter sharing one 4-phase mesh link
module mesh_link_arbiter
    import mesh_link_pkg::*;
#(
    parameter int N_PORTS = 4
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [N_PORTS-1:0]     In_Req,
    input  logic [32*N_PORTS-1:0]  In_Data,
    output logic [N_PORTS-1:0]     In_Ack,
    output logic                   Out_Req,
    output logic [31:0]            Out_Data,
    input  logic                   Out_Ack,
    output logic [2:0]             Grant_Id,
    output logic                   Busy
);

    localparam int IW = $clog2(N_PORTS);

    state_t                state;
    logic [IW-1:0]         g;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         pick;
    logic                  pick_valid;
    logic [WORD_CNT_W-1:0] cnt;
    logic [31:0]           words [N_PORTS];

    for (genvar i = 0; i < N_PORTS; i++) begin : g_words
        assign words[i] = In_Data[32*i +: 32];
    end

    rr_picker #(.N_PORTS(N_PORTS)) u_picker (
        .req       (In_Req),
        .ptr       (ptr),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick)
    );

    assign Grant_Id = 3'(g);
    assign Busy = state != IDLE;

    // Packet FSM: owner keeps the link for every word of its packet, handshakes relayed both ways
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
            g <= '0;
            ptr <= '0;
            cnt <= '0;
            Out_Req <= 1'b0;
            Out_Data <= '0;
            In_Ack <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    state <= SEND;
                    g <= pick;
                    Out_Data <= words[pick];
                    Out_Req <= 1'b1;
                    cnt <= HDR_WORDS(words[pick][HDR_LEN_LSB +: HDR_FIELD_W]) - 1'b1;
                end
                SEND: if (Out_Ack) begin
                    In_Ack[g] <= 1'b1;
                    state <= WAIT_RLS;
                end
                WAIT_RLS: if (!In_Req[g]) begin
                    Out_Req <= 1'b0;
                    state <= WAIT_ACKLO;
                end
                WAIT_ACKLO: if (!Out_Ack) begin
                    In_Ack[g] <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                        ptr <= g == IW'(N_PORTS - 1) ? '0 : g + 1'b1;
                        g <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        state <= NEXT;
                    end
                end
                NEXT: if (In_Req[g]) begin
                    Out_Data <= words[g];
                    Out_Req <= 1'b1;
                    state <= SEND;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_link_arbiter.sv
// tb_mesh_link_arbiter: directed and randomized packet traffic checked against a round-robin packet model
module tb_mesh_link_arbiter;

    localparam int N = 4;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic [N-1:0]  In_Req = '0;
    logic [32*N-1:0] In_Data = '0;
    logic [N-1:0]  In_Ack;
    logic          Out_Req;
    logic [31:0]   Out_Data;
    logic          Out_Ack = 1'b0;
    logic [2:0]    Grant_Id;
    logic          Busy;

    mesh_link_arbiter #(.N_PORTS(N)) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .In_Req   (In_Req),
        .In_Data  (In_Data),
        .In_Ack   (In_Ack),
        .Out_Req  (Out_Req),
        .Out_Data (Out_Data),
        .Out_Ack  (Out_Ack),
        .Grant_Id (Grant_Id),
        .Busy     (Busy)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;
    logic [32:0] drv_q [N][$];
    logic [32:0] mdl_q [N][$];
    logic [34:0] log_q [$];
    logic [34:0] exp_q [$];
    int dly [N];
    int md = 0;
    int mptr = 0;
    bit auto_on = 1'b0;
    logic prev_req = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Packet of 1 + ceil(len/4) words; bit 32 marks the header word
    task automatic add_pkt(input int p, input int len);
        logic [32:0] w;
        w = {1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'(len), 8'(p)};
        drv_q[p].push_back(w);
        mdl_q[p].push_back(w);
        for (int k = 0; k < (len + 3) / 4; k++) begin
            w = {1'b0, 32'($urandom)};
            drv_q[p].push_back(w);
            mdl_q[p].push_back(w);
        end
    endtask

    // Reference: whole packets served in round-robin order from the pointer
    task automatic model();
        int g;
        bit found;
        logic [32:0] w;
        exp_q.delete();
        forever begin
            found = 1'b0;
            g = 0;
            for (int k = 0; k < N; k++)
                if (!found && mdl_q[(mptr + k) % N].size() > 0) begin
                    found = 1'b1;
                    g = (mptr + k) % N;
                end
            if (!found) break;
            w = mdl_q[g].pop_front();
            exp_q.push_back({3'(g), w[31:0]});
            while (mdl_q[g].size() > 0 && !mdl_q[g][0][32]) begin
                w = mdl_q[g].pop_front();
                exp_q.push_back({3'(g), w[31:0]});
            end
            mptr = (g + 1) % N;
        end
    endtask

    // Requesters present headers immediately and later words after a random gap; mesh acks after a random delay
    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (In_Req[p]) begin
                if (In_Ack[p]) begin
                    In_Req[p] = 1'b0;
                    void'(drv_q[p].pop_front());
                    dly[p] = $urandom_range(0, 2);
                end
            end else if (!In_Ack[p] && drv_q[p].size() > 0) begin
                if (drv_q[p][0][32] || dly[p] == 0) begin
                    In_Req[p] = 1'b1;
                    In_Data[32*p +: 32] = drv_q[p][0][31:0];
                end else begin
                    dly[p]--;
                end
            end
        end
        if (Out_Req != Out_Ack) begin
            if (md == 0) begin
                Out_Ack = Out_Req;
                md = $urandom_range(0, 3);
            end else begin
                md--;
            end
        end
    endtask

    task automatic tick();
        @(negedge HCLK);
        if (auto_on) drive();
        @(posedge HCLK);
        #1;
        if (Out_Req && !prev_req) log_q.push_back({Grant_Id, Out_Data});
        if (Out_Req && prev_req) chk("data_stable", 64'(Out_Data), 64'(prev_data));
        if (!Busy) chk("idle_ack", 64'(In_Ack), 64'd0);
        chk("ack_onehot", 64'($onehot0(In_Ack)), 64'd1);
        prev_req = Out_Req;
        prev_data = Out_Data;
    endtask

    function automatic bit quiet();
        bit q;
        q = !Busy && !Out_Req && !Out_Ack && In_Req == '0;
        for (int p = 0; p < N; p++) if (drv_q[p].size() != 0) q = 1'b0;
        return q;
    endfunction

    function automatic logic [2:0] gid(input int i);
        return i < log_q.size() ? log_q[i][34:32] : 3'b111;
    endfunction

    task automatic run_batch(input string tag);
        int c;
        model();
        log_q.delete();
        c = 0;
        do begin
            tick();
            c++;
        end while (c < 4000 && !quiet());
        chk({tag, "_done"}, 64'(c < 4000), 64'd1);
        chk({tag, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk({tag, "_word"}, 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int acks;
        logic prev_ack;
        for (int p = 0; p < N; p++) dly[p] = 0;
        repeat (3) tick();
        chk("rst_out_req", 64'(Out_Req), 64'd0);
        chk("rst_out_data", 64'(Out_Data), 64'd0);
        chk("rst_in_ack", 64'(In_Ack), 64'd0);
        chk("rst_grant", 64'(Grant_Id), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        HRESET = 1'b0;
        tick();

        Out_Ack = 1'b1;
        repeat (3) tick();
        chk("idle_stray_ack", 64'(In_Ack), 64'd0);
        chk("idle_stray_busy", 64'(Busy), 64'd0);
        chk("idle_stray_req", 64'(Out_Req), 64'd0);
        Out_Ack = 1'b0;
        tick();
        auto_on = 1'b1;

        add_pkt(1, 8);
        run_batch("single");
        chk("single_words", 64'(log_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("single_grant", 64'(gid(i)), 64'd1);

        add_pkt(0, 0);
        add_pkt(2, 0);
        run_batch("ptr2");
        chk("ptr2_first", 64'(gid(0)), 64'd2);
        chk("ptr2_second", 64'(gid(1)), 64'd0);

        add_pkt(1, 8);
        mdl_q[1].delete();
        acks = 0;
        prev_ack = 1'b0;
        for (int c = 0; c < 500 && acks < 2; c++) begin
            tick();
            if (In_Ack[1] && !prev_ack) acks++;
            prev_ack = In_Ack[1];
        end
        chk("mid_reach", 64'(acks), 64'd2);
        auto_on = 1'b0;
        HRESET = 1'b1;
        In_Req = '0;
        drv_q[1].delete();
        tick();
        chk("mid_out_req", 64'(Out_Req), 64'd0);
        chk("mid_out_data", 64'(Out_Data), 64'd0);
        chk("mid_in_ack", 64'(In_Ack), 64'd0);
        chk("mid_grant", 64'(Grant_Id), 64'd0);
        chk("mid_busy", 64'(Busy), 64'd0);
        HRESET = 1'b0;
        mptr = 0;
        auto_on = 1'b1;
        for (int c = 0; c < 20 && Out_Ack; c++) tick();
        chk("mid_ack_low", 64'(Out_Ack), 64'd0);

        add_pkt(0, 4);
        add_pkt(2, 4);
        add_pkt(3, 4);
        run_batch("contend");
        chk("contend_g0", 64'(gid(0)), 64'd0);
        chk("contend_g1", 64'(gid(2)), 64'd2);
        chk("contend_g2", 64'(gid(4)), 64'd3);

        add_pkt(2, 0);
        run_batch("len0");
        chk("len0_words", 64'(log_q.size()), 64'd1);
        add_pkt(0, 255);
        run_batch("len255");
        chk("len255_words", 64'(log_q.size()), 64'd65);
        add_pkt(2, 5);
        run_batch("len5");
        chk("len5_words", 64'(log_q.size()), 64'd3);

        add_pkt(0, 0);
        add_pkt(3, 0);
        run_batch("wrap");
        chk("wrap_first", 64'(gid(0)), 64'd3);
        chk("wrap_second", 64'(gid(1)), 64'd0);
        add_pkt(0, 0);
        add_pkt(1, 0);
        run_batch("wrap_ptr1");
        chk("wrap_ptr1_first", 64'(gid(0)), 64'd1);

        for (int r = 0; r < 8; r++) begin
            bit any;
            any = 1'b0;
            for (int p = 0; p < N; p++)
                if ($urandom_range(0, 1) == 1) begin
                    any = 1'b1;
                    for (int k = 0; k < int'($urandom_range(1, 2)); k++) add_pkt(p, int'($urandom_range(0, 24)));
                end
            if (!any) add_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 24)));
            run_batch("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mesh_link_arbiter.md
MESH_LINK_ARBITER -- requirements
Module: mesh_link_arbiter

Interface
REQ-001 Parameter N_PORTS SHALL default to 4: number of requesters sharing one mesh output link (range 2..8).
REQ-002 Port HCLK, input, 1: single clock; every register SHALL be clocked on its rising edge.
REQ-003 Port HRESET, input, 1: reset; one clock, reset synchronous and active-high.
REQ-004 Port In_Req, input, N_PORTS: per-requester 4-phase request; In_Data is stable while high.
REQ-005 Port In_Data, input, 32*N_PORTS: per-requester word; port i occupies bits [32i+31:32i].
REQ-006 Port In_Ack, output, N_PORTS: per-requester 4-phase acknowledge.
REQ-007 Port Out_Req, output, 1: link request toward the mesh, same protocol as M_Req.
REQ-008 Port Out_Data, output, 32: registered link word.
REQ-009 Port Out_Ack, input, 1: link acknowledge from the mesh.
REQ-010 Port Grant_Id, output, 3: index of the current owner; 0 when idle.
REQ-011 Port Busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 The link SHALL be granted per packet; the first word of a packet is the header: [31:24] Mes_Type, [23:16] Des_Addr, [15:8] Byte_Len, [7:0] source.
REQ-013 Packet length SHALL be 1 + ceil(Byte_Len/4) words (1..65), held in a 7-bit down-counter loaded from the header.
REQ-014 States SHALL be IDLE, SEND, WAIT_RLS, WAIT_ACKLO and NEXT.
REQ-015 IDLE: if any In_Req bit is high at edge T, grant the first requester at or after the priority pointer (wrapping). At T+1: state=SEND, Grant_Id=g, Out_Data=In_Data[g], Out_Req=1, counter=words-1.
REQ-016 SEND: Out_Ack high → next cycle In_Ack[g]=1, state WAIT_RLS.
REQ-017 WAIT_RLS: In_Req[g] low → next cycle Out_Req=0, state WAIT_ACKLO.
REQ-018 WAIT_ACKLO: Out_Ack low → next cycle In_Ack[g]=0.
REQ-019 WAIT_ACKLO exit: if counter==0, state=IDLE and pointer=(g+1) mod N_PORTS; otherwise counter decrements and state=NEXT.
REQ-020 NEXT: In_Req[g] high → capture In_Data[g] into Out_Data, set Out_Req=1, state SEND. Requests from other ports SHALL be ignored until the packet completes.
REQ-021 Out_Data SHALL change only on the capture cycles in REQ-015 and REQ-020, and never while Out_Req is high.
REQ-022 In IDLE, Out_Ack high SHALL be ignored and In_Ack SHALL stay 0.
REQ-023 At most one In_Ack bit SHALL be high in any cycle.
REQ-024 Protocol violations (In_Req[g] dropped in SEND, Out_Ack dropped in WAIT_RLS) SHALL NOT abort the packet; the FSM waits for the expected level.
REQ-025 Simultaneous requests: under continuous contention, every port SHALL win within N_PORTS packets.

Reset
REQ-026 HRESET high at an edge SHALL force state=IDLE, Out_Req=0, Out_Data=0, In_Ack=0, Grant_Id=0, Busy=0, pointer=0, counter=0, including mid-packet; the partial packet is dropped.

Structure
REQ-027 Package mesh_link_pkg SHALL hold: the state enum; header field positions; the HDR_WORDS function (Byte_Len→words); the WORD_CNT_W=7 constant.
REQ-028 Sub-module rr_picker SHALL be used: combinational round-robin priority picker with inputs req and pointer, and outputs gnt_valid and gnt_idx.

Verification
REQ-029 Single packet: port 1 sends header Byte_Len=8 → exactly 3 Out_Req pulses; Out_Data sequence equals the input words; Grant_Id=1 throughout; IDLE afterwards with pointer=2.
REQ-030 Contention: ports 0, 2 and 3 request in the same cycle with pointer=0 → grant order 0, 2, 3; no interleaving of words.
REQ-031 Byte_Len=0 → one word only; Byte_Len=255 → 65 words; Byte_Len=5 → 3 words.
REQ-032 Wrap: pointer=3, ports 0 and 3 request → port 3 first, then port 0, then pointer=1.
REQ-033 Reset mid-packet: HRESET asserted in WAIT_RLS of word 2 → all outputs 0 next cycle. A later request is granted cleanly from pointer 0.
REQ-034 Assertions on every bench: REQ-021 (Out_Data stable while Out_Req high), REQ-022 (In_Ack=0 in IDLE), REQ-023 (In_Ack one-hot or zero).
